// File: rtl/ysyx_24120009_stage_ctrl_pkg.sv
// Shared definitions for the multi-cycle stage controller.
// Holds the controller state encoding (also exported on state_debug), the
// next-PC select encodings, the default reset PC and timeout, and a small
// helper that aligns a jalr target.
package ysyx_24120009_stage_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALTED = 3'd6,
        S_FAULT  = 3'd7
    } stage_state_e;

    localparam logic [2:0]  PC_SEL_SEQ    = 3'b000;
    localparam logic [2:0]  PC_SEL_JALR   = 3'b001;
    localparam logic [2:0]  PC_SEL_BRANCH = 3'b010;
    localparam logic [2:0]  PC_SEL_JAL    = 3'b011;

    localparam logic [31:0] RESET_PC_DEFAULT    = 32'h8000_0000;
    localparam int          MEM_TIMEOUT_DEFAULT = 256;

    // jalr drops bit 0 of the computed register target.
    function automatic logic [31:0] jalr_align(input logic [31:0] target);
        return {target[31:1], 1'b0};
    endfunction

endpackage

// File: rtl/ysyx_24120009_MuxKey.sv
// Generic key/value selector.
// Ports:
//   out         - data of the lut entry whose key equals `key`, else default_out
//   key         - selection key
//   default_out - value used when no entry matches
//   lut         - packed table, entry i = {key_i, data_i} at bits [i*(K+D) +: K+D]
module ysyx_24120009_MuxKey #(
    parameter int NR_KEY   = 2,
    parameter int KEY_LEN  = 1,
    parameter int DATA_LEN = 1
) (
    output logic [DATA_LEN-1:0]                  out,
    input  logic [KEY_LEN-1:0]                   key,
    input  logic [DATA_LEN-1:0]                  default_out,
    input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut
);

    localparam int ENTRY_W = KEY_LEN + DATA_LEN;

    logic [DATA_LEN-1:0] sel_data_s;

    // Scan every entry; keys are expected to be unique so order does not matter.
    always_comb begin
        sel_data_s = default_out;
        for (int i = 0; i < NR_KEY; i++) begin
            sel_data_s = (lut[i*ENTRY_W + DATA_LEN +: KEY_LEN] == key)
                       ? lut[i*ENTRY_W +: DATA_LEN] : sel_data_s;
        end
    end

    assign out = sel_data_s;

endmodule

// File: rtl/ysyx_24120009_stage_ctrl.sv
// Multi-cycle instruction stage controller:
// IDLE -> FETCH -> DECODE -> EXEC -> [MEM] -> WB -> FETCH ..., with absorbing
// HALTED (ebreak) and FAULT (timeout / memory error) states.
// Ports:
//   clk, rst                      - clock, synchronous active-low reset
//   ifu_req / ifu_done            - fetch handshake (req held until done)
//   inst_valid / id_done          - decode start pulse / decode complete
//   pc_sel, *_target              - next-PC select and candidates (valid with id_done)
//   ex_start / ex_done, is_mem    - execute start pulse / complete, load-store flag
//   lsu_start / lsu_done, lsu_err - memory start pulse / complete / error
//   halt                          - ebreak indication, sampled in WB
//   wb_en                         - one-cycle register write-back enable
//   pc, instret, fault            - current PC, retired count, sticky fault
//   state_debug                   - current state encoding
// All outputs are registered; pulse outputs are derived from the next state
// so they line up with the cycle the FSM is actually in that state.
module ysyx_24120009_stage_ctrl
    import ysyx_24120009_stage_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int          MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ifu_req,
    input  logic        ifu_done,
    output logic        inst_valid,
    input  logic        id_done,
    input  logic [2:0]  pc_sel,
    input  logic [31:0] jump_reg_target,
    input  logic [31:0] br_target,
    input  logic [31:0] jmp_target,
    output logic        ex_start,
    input  logic        ex_done,
    input  logic        is_mem,
    output logic        lsu_start,
    input  logic        lsu_done,
    input  logic        lsu_err,
    input  logic        halt,
    output logic        wb_en,
    output logic [31:0] pc,
    output logic [31:0] instret,
    output logic        fault,
    output logic [2:0]  state_debug
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    stage_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  next_pc_q, next_pc_d;
    logic [31:0]  instret_q, instret_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic         fault_q, fault_d;
    logic         ifu_req_q, ifu_req_d;
    logic         inst_valid_q, inst_valid_d;
    logic         ex_start_q, ex_start_d;
    logic         lsu_start_q, lsu_start_d;
    logic         wb_en_q, wb_en_d;

    logic [31:0]  pc_plus4_s;
    logic [31:0]  npc_sel_s;
    logic         timeout_s;
    logic         entered_s;

    assign pc_plus4_s = pc_q + 32'd4;
    assign timeout_s  = (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

    // Unlisted pc_sel codes fall through to the sequential default.
    ysyx_24120009_MuxKey #(
        .NR_KEY   (4),
        .KEY_LEN  (3),
        .DATA_LEN (32)
    ) u_npc_mux (
        .out         (npc_sel_s),
        .key         (pc_sel),
        .default_out (pc_plus4_s),
        .lut         ({PC_SEL_JAL,    jmp_target,
                       PC_SEL_BRANCH, br_target,
                       PC_SEL_JALR,   jalr_align(jump_reg_target),
                       PC_SEL_SEQ,    pc_plus4_s})
    );

    // Next-state, architectural updates, wait counter and next output values.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        next_pc_d = next_pc_q;
        instret_d = instret_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                // done is checked first so it wins over a coincident timeout
                if (ifu_done) begin
                    state_d = S_DECODE;
                end else if (timeout_s) begin
                    state_d = S_FAULT;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                if (id_done) begin
                    next_pc_d = npc_sel_s;
                    state_d   = S_EXEC;
                end else begin
                    state_d   = S_DECODE;
                end
            end
            S_EXEC: begin
                if (ex_done) begin
                    state_d = is_mem ? S_MEM : S_WB;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_MEM: begin
                // error beats done, done beats timeout
                if (lsu_err) begin
                    state_d = S_FAULT;
                end else if (lsu_done) begin
                    state_d = S_WB;
                end else if (timeout_s) begin
                    state_d = S_FAULT;
                end else begin
                    state_d = S_MEM;
                end
            end
            S_WB: begin
                pc_d      = next_pc_q;
                instret_d = instret_q + 32'd1;
                state_d   = halt ? S_HALTED : S_FETCH;
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase

        entered_s = (state_d != state_q);

        if (entered_s) begin
            cnt_d = '0;
        end else if ((state_q == S_FETCH) || (state_q == S_MEM)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = '0;
        end

        ifu_req_d    = (state_d == S_FETCH);
        inst_valid_d = (state_d == S_DECODE) && entered_s;
        ex_start_d   = (state_d == S_EXEC)   && entered_s;
        lsu_start_d  = (state_d == S_MEM)    && entered_s;
        wb_en_d      = (state_d == S_WB);
        fault_d      = fault_q || (state_d == S_FAULT);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            next_pc_q    <= RESET_PC + 32'd4;
            instret_q    <= 32'd0;
            cnt_q        <= '0;
            fault_q      <= 1'b0;
            ifu_req_q    <= 1'b0;
            inst_valid_q <= 1'b0;
            ex_start_q   <= 1'b0;
            lsu_start_q  <= 1'b0;
            wb_en_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            next_pc_q    <= next_pc_d;
            instret_q    <= instret_d;
            cnt_q        <= cnt_d;
            fault_q      <= fault_d;
            ifu_req_q    <= ifu_req_d;
            inst_valid_q <= inst_valid_d;
            ex_start_q   <= ex_start_d;
            lsu_start_q  <= lsu_start_d;
            wb_en_q      <= wb_en_d;
        end
    end

    assign ifu_req     = ifu_req_q;
    assign inst_valid  = inst_valid_q;
    assign ex_start    = ex_start_q;
    assign lsu_start   = lsu_start_q;
    assign wb_en       = wb_en_q;
    assign pc          = pc_q;
    assign instret     = instret_q;
    assign fault       = fault_q;
    assign state_debug = state_q;

endmodule

// File: tb/tb_ysyx_24120009_stage_ctrl.sv
// Self-checking bench for ysyx_24120009_stage_ctrl: a table of directed
// instructions with hand-computed results, a reset-abort sequence and a
// randomized instruction stream checked against a schedule/PC model.
module tb_ysyx_24120009_stage_ctrl;

    localparam logic [31:0] RPC = 32'h8000_0000;
    localparam int          TMO = 256;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_HALTED = 3'd6;
    localparam logic [2:0] ST_FAULT  = 3'd7;

    // how an instruction ends
    localparam int E_DONE = 0;  // memory (if any) completes at dm
    localparam int E_ERR  = 1;  // lsu_err at dm
    localparam int E_BOTH = 2;  // lsu_err and lsu_done together at dm
    localparam int E_MTO  = 3;  // memory never completes
    localparam int E_FTO  = 4;  // fetch never completes

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] jr, br, jt;
        bit          mem;
        int          df, dd, de, dm;
        int          kind;
        bit          hlt;
        logic [31:0] exp_pc;
        logic [31:0] exp_instret;
        logic [2:0]  exp_state;
        logic        exp_fault;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        ifu_req, ifu_done, inst_valid, id_done;
    logic [2:0]  pc_sel;
    logic [31:0] jump_reg_target, br_target, jmp_target;
    logic        ex_start, ex_done, is_mem, lsu_start, lsu_done, lsu_err, halt, wb_en;
    logic [31:0] pc, instret;
    logic        fault;
    logic [2:0]  state_debug;

    int pass_cnt;
    int total_cnt;
    vec_t tbl [14];

    ysyx_24120009_stage_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .ifu_req         (ifu_req),
        .ifu_done        (ifu_done),
        .inst_valid      (inst_valid),
        .id_done         (id_done),
        .pc_sel          (pc_sel),
        .jump_reg_target (jump_reg_target),
        .br_target       (br_target),
        .jmp_target      (jmp_target),
        .ex_start        (ex_start),
        .ex_done         (ex_done),
        .is_mem          (is_mem),
        .lsu_start       (lsu_start),
        .lsu_done        (lsu_done),
        .lsu_err         (lsu_err),
        .halt            (halt),
        .wb_en           (wb_en),
        .pc              (pc),
        .instret         (instret),
        .fault           (fault),
        .state_debug     (state_debug)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic randomize_inputs();
        ifu_done        = 1'($urandom);
        id_done         = 1'($urandom);
        ex_done         = 1'($urandom);
        is_mem          = 1'($urandom);
        lsu_done        = 1'($urandom);
        lsu_err         = 1'($urandom);
        halt            = 1'($urandom);
        pc_sel          = 3'($urandom);
        jump_reg_target = $urandom;
        br_target       = $urandom;
        jmp_target      = $urandom;
    endtask

    function automatic logic [31:0] ref_next_pc(input logic [31:0] cur, input vec_t v);
        case (v.sel)
            3'd1:    return v.jr & 32'hFFFF_FFFE;
            3'd2:    return v.br;
            3'd3:    return v.jt;
            default: return cur + 32'd4;
        endcase
    endfunction

    function automatic vec_t mk(input logic [2:0] sel, input logic [31:0] jr, input logic [31:0] br,
                                input logic [31:0] jt, input bit mem, input int df, input int dd,
                                input int de, input int dm, input int kind, input bit hlt,
                                input logic [31:0] epc, input logic [31:0] eir,
                                input logic [2:0] est, input logic ef);
        vec_t v;
        v.sel = sel; v.jr = jr; v.br = br; v.jt = jt; v.mem = mem;
        v.df = df; v.dd = dd; v.de = de; v.dm = dm; v.kind = kind; v.hlt = hlt;
        v.exp_pc = epc; v.exp_instret = eir; v.exp_state = est; v.exp_fault = ef;
        return v;
    endfunction

    // Reset for one cycle with random inputs, check the reset state, release.
    task automatic do_reset();
        rst = 1'b0;
        randomize_inputs();
        tick();
        chk("rst_state", 32'(state_debug), 32'(ST_IDLE));
        chk("rst_pc", pc, RPC);
        chk("rst_instret", instret, 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_outputs", 32'({ifu_req, inst_valid, ex_start, lsu_start, wb_en}), 32'd0);
        rst = 1'b1;
        tick();
    endtask

    // Drive one instruction from its first FETCH cycle. Every cycle is compared
    // to the schedule implied by the done delays; done/halt/select inputs carry
    // random noise whenever the FSM is not in the state that samples them.
    task automatic run_instr(input vec_t v, output logic [31:0] o_pc, output logic [31:0] o_instret,
                             output logic [2:0] o_state, output logic o_fault, output int o_bad);
        int dec_s, ex_s, ex_e, mem_last, wb_c, n;
        logic [2:0] ph;
        o_bad = 0;
        dec_s    = (v.kind == E_FTO) ? TMO : v.df + 1;
        ex_s     = dec_s + v.dd + 1;
        ex_e     = ex_s + v.de + 1;
        mem_last = (v.kind == E_MTO) ? ex_e + TMO - 1 : ex_e + v.dm;
        if (!v.mem)                 wb_c = ex_e;
        else if (v.kind == E_DONE)  wb_c = mem_last + 1;
        else                        wb_c = -1;
        if (v.kind == E_FTO)        n = TMO;
        else if (wb_c >= 0)         n = wb_c + 1;
        else                        n = mem_last + 1;

        for (int c = 0; c < n; c++) begin
            if (c < dec_s)                      ph = ST_FETCH;
            else if (c < ex_s)                  ph = ST_DECODE;
            else if (c < ex_e)                  ph = ST_EXEC;
            else if (v.mem && c <= mem_last)    ph = ST_MEM;
            else                                ph = ST_WB;

            if (state_debug !== ph || ifu_req !== (ph == ST_FETCH) ||
                inst_valid !== (c == dec_s) || ex_start !== (c == ex_s) ||
                lsu_start !== (v.mem && c == ex_e) || wb_en !== (c == wb_c) ||
                fault !== 1'b0) begin
                o_bad++;
            end

            randomize_inputs();
            if (ph == ST_FETCH) begin
                ifu_done = (v.kind != E_FTO) && (c == v.df);
            end
            if (ph == ST_DECODE) begin
                id_done = (c == ex_s - 1);
                if (c == ex_s - 1) begin
                    pc_sel = v.sel; jump_reg_target = v.jr; br_target = v.br; jmp_target = v.jt;
                end
            end
            if (ph == ST_EXEC) begin
                ex_done = (c == ex_e - 1);
                is_mem  = v.mem;
            end
            if (ph == ST_MEM) begin
                lsu_done = (c == mem_last) && (v.kind == E_DONE || v.kind == E_BOTH);
                lsu_err  = (c == mem_last) && (v.kind == E_ERR  || v.kind == E_BOTH);
            end
            if (ph == ST_WB) begin
                halt = v.hlt;
            end
            tick();
        end
        o_pc = pc; o_instret = instret; o_state = state_debug; o_fault = fault;
    endtask

    // In an absorbing state nothing may move and no request/pulse may appear.
    task automatic idle_check(input string name, input int n, input logic [2:0] est,
                              input logic [31:0] epc, input logic [31:0] eir, input logic ef);
        int bad;
        bad = 0;
        for (int c = 0; c < n; c++) begin
            randomize_inputs();
            tick();
            if (state_debug !== est || pc !== epc || instret !== eir || fault !== ef ||
                {ifu_req, inst_valid, ex_start, lsu_start, wb_en} !== 5'd0) begin
                bad++;
            end
        end
        chk(name, bad, 32'd0);
    endtask

    initial begin
        logic [31:0] o_pc, o_ir, m_pc, m_ir, npc;
        logic [2:0]  o_st;
        logic        o_f;
        int          bad;
        vec_t        v;

        pass_cnt = 0;
        total_cnt = 0;
        rst = 1'b1;
        randomize_inputs();

        //            sel   jr            br            jt            mem df   dd de dm   kind    hlt  pc            instret state      fault
        tbl[0]  = mk(3'd0, 32'h1111_1110, 32'h2222_2220, 32'h3333_3330, 0, 0,   0, 0, 0,   E_DONE, 0, 32'h8000_0004, 32'd1, ST_FETCH,  1'b0);
        tbl[1]  = mk(3'd1, 32'h8000_0103, 32'h2222_2220, 32'h3333_3330, 0, 0,   0, 0, 0,   E_DONE, 0, 32'h8000_0102, 32'd1, ST_FETCH,  1'b0);
        tbl[2]  = mk(3'd2, 32'h1111_1111, 32'h8000_1230, 32'h3333_3330, 0, 0,   2, 0, 0,   E_DONE, 0, 32'h8000_1230, 32'd1, ST_FETCH,  1'b0);
        tbl[3]  = mk(3'd3, 32'h1111_1111, 32'h2222_2220, 32'h8000_ABC0, 0, 3,   0, 1, 0,   E_DONE, 0, 32'h8000_ABC0, 32'd1, ST_FETCH,  1'b0);
        tbl[4]  = mk(3'd5, 32'h1111_1111, 32'h2222_2220, 32'h3333_3330, 0, 1,   1, 1, 0,   E_DONE, 0, 32'h8000_0004, 32'd1, ST_FETCH,  1'b0);
        tbl[5]  = mk(3'd7, 32'h1111_1111, 32'h2222_2220, 32'h3333_3330, 0, 0,   0, 0, 0,   E_DONE, 0, 32'h8000_0004, 32'd1, ST_FETCH,  1'b0);
        tbl[6]  = mk(3'd0, 32'h1111_1111, 32'h2222_2220, 32'h3333_3330, 1, 0,   0, 0, 10,  E_DONE, 0, 32'h8000_0004, 32'd1, ST_FETCH,  1'b0);
        tbl[7]  = mk(3'd0, 32'h1111_1111, 32'h2222_2220, 32'h3333_3330, 1, 0,   0, 0, 0,   E_MTO,  0, 32'h8000_0000, 32'd0, ST_FAULT,  1'b1);
        tbl[8]  = mk(3'd2, 32'h1111_1111, 32'h2222_2220, 32'h3333_3330, 1, 0,   0, 0, 2,   E_BOTH, 0, 32'h8000_0000, 32'd0, ST_FAULT,  1'b1);
        tbl[9]  = mk(3'd0, 32'h1111_1111, 32'h2222_2220, 32'h3333_3330, 1, 0,   0, 0, 0,   E_ERR,  0, 32'h8000_0000, 32'd0, ST_FAULT,  1'b1);
        tbl[10] = mk(3'd1, 32'h8000_0FFF, 32'h2222_2220, 32'h3333_3330, 1, 0,   0, 0, 255, E_DONE, 0, 32'h8000_0FFE, 32'd1, ST_FETCH,  1'b0);
        tbl[11] = mk(3'd0, 32'h1111_1111, 32'h2222_2220, 32'h3333_3330, 0, 0,   0, 0, 0,   E_FTO,  0, 32'h8000_0000, 32'd0, ST_FAULT,  1'b1);
        tbl[12] = mk(3'd2, 32'h1111_1111, 32'h8000_0400, 32'h3333_3330, 0, 0,   0, 0, 0,   E_DONE, 1, 32'h8000_0400, 32'd1, ST_HALTED, 1'b0);
        tbl[13] = mk(3'd0, 32'h1111_1111, 32'h2222_2220, 32'h3333_3330, 0, 255, 0, 0, 0,   E_DONE, 0, 32'h8000_0004, 32'd1, ST_FETCH,  1'b0);

        // Directed table, each entry from a fresh reset.
        for (int i = 0; i < 14; i++) begin
            do_reset();
            run_instr(tbl[i], o_pc, o_ir, o_st, o_f, bad);
            chk($sformatf("v%0d_trace", i), bad, 32'd0);
            chk($sformatf("v%0d_pc", i), o_pc, tbl[i].exp_pc);
            chk($sformatf("v%0d_instret", i), o_ir, tbl[i].exp_instret);
            chk($sformatf("v%0d_state", i), 32'(o_st), 32'(tbl[i].exp_state));
            chk($sformatf("v%0d_fault", i), 32'(o_f), 32'(tbl[i].exp_fault));
            if (tbl[i].exp_state != ST_FETCH) begin
                idle_check($sformatf("v%0d_absorb", i), 20, tbl[i].exp_state,
                           tbl[i].exp_pc, tbl[i].exp_instret, tbl[i].exp_fault);
            end
        end

        // Reset in the middle of MEM, with lsu_done arriving on the reset edge.
        do_reset();
        ifu_done = 1'b1; id_done = 1'b1; ex_done = 1'b1; is_mem = 1'b1;
        lsu_done = 1'b0; lsu_err = 1'b0; halt = 1'b0; pc_sel = 3'd0;
        tick();
        tick();
        tick();
        chk("abort_in_mem", 32'(state_debug), 32'(ST_MEM));
        tick();
        lsu_done = 1'b1;
        rst = 1'b0;
        tick();
        chk("abort_state", 32'(state_debug), 32'(ST_IDLE));
        chk("abort_wb_en", 32'(wb_en), 32'd0);
        chk("abort_instret", instret, 32'd0);
        chk("abort_pc", pc, RPC);
        rst = 1'b1;
        lsu_done = 1'b0;
        tick();
        chk("abort_refetch", 32'(state_debug), 32'(ST_FETCH));
        chk("abort_no_wb", 32'({wb_en, instret}), 32'd0);

        // Randomized instruction stream against the PC/instret model.
        do_reset();
        m_pc = RPC;
        m_ir = 32'd0;
        for (int k = 0; k < 160; k++) begin
            v = mk(3'($urandom), $urandom, $urandom, $urandom, ($urandom_range(3, 0) == 0),
                   $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(3, 0),
                   $urandom_range(5, 0), E_DONE, 1'b0, 32'd0, 32'd0, ST_FETCH, 1'b0);
            if (k == 5) begin
                v.sel = 3'd3;
                v.jt  = 32'hFFFF_FFFC;
            end
            if (k == 6) begin
                v.sel = 3'd0;
            end
            npc = ref_next_pc(m_pc, v);
            run_instr(v, o_pc, o_ir, o_st, o_f, bad);
            chk($sformatf("r%0d_trace", k), bad, 32'd0);
            chk($sformatf("r%0d_pc", k), o_pc, npc);
            chk($sformatf("r%0d_instret", k), o_ir, m_ir + 32'd1);
            chk($sformatf("r%0d_state", k), 32'({o_f, o_st}), 32'({1'b0, ST_FETCH}));
            m_pc = npc;
            m_ir = m_ir + 32'd1;
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
